// File: rtl/gate_eval_sched_pkg.sv
// Shared definitions for the gate evaluation scheduler: FSM states,
// opcodes and the delay counter width.
package gate_eval_pkg;

  localparam int CNTW = 4;

  localparam logic OP_BUF  = 1'b0;
  localparam logic OP_AND2 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/gate_eval_sched_if.sv
// Client-side bundle of the scheduler: packed per-client requests/operands in,
// grant pulse and tagged result out.
interface gate_eval_sched_if #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2
);

  logic [N-1:0]   req;
  logic [N-1:0]   op;
  logic [N*W-1:0] a;
  logic [N*W-1:0] b;
  logic [N-1:0]   gnt;
  logic           busy;
  logic [W-1:0]   z;
  logic           z_valid;
  logic [IDW-1:0] z_id;

  modport master (
    output req, op, a, b,
    input  gnt, busy, z, z_valid, z_id
  );

  modport slave (
    input  req, op, a, b,
    output gnt, busy, z, z_valid, z_id
  );

endinterface

// File: rtl/gate_eval_sched_rr_pick.sv
// Combinational round-robin pick: first set request scanning ptr+1, ptr+2, ...
// modulo N, so the last winner ends up with the lowest priority.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           any_o,
  output logic [IDW-1:0] sel_o,
  output logic [N-1:0]   onehot_o
);

  logic [IDW-1:0] cand;

  always_comb begin
    any_o    = 1'b0;
    sel_o    = '0;
    onehot_o = '0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        sel_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_eval_sched.sv
// Shares one fixed-delay BUF/AND2 evaluation unit among N clients:
// arbitrate, grant, count down DIZ cycles, then broadcast the tagged result.
module gate_eval_sched
  import gate_eval_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int DIZ = 6,
  parameter int IDW = 2
) (
  input logic              clk,
  input logic              reset,
  gate_eval_sched_if.slave bus
);

  state_e            state_q;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    sel_q;
  logic [CNTW-1:0]   cnt_q;
  logic [W-1:0]      res_q;
  logic [N-1:0]      gnt_q;
  logic              busy_q;
  logic [W-1:0]      z_q;
  logic              zValid_q;
  logic [IDW-1:0]    zId_q;

  logic              pickAny;
  logic [IDW-1:0]    pickSel;
  logic [N-1:0]      pickOnehot;
  logic [W-1:0]      aSel;
  logic [W-1:0]      bSel;
  logic [W-1:0]      res_d;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .any_o    (pickAny),
    .sel_o    (pickSel),
    .onehot_o (pickOnehot)
  );

  // The granted client only guarantees its operands during the GRANT cycle,
  // so the gate result is evaluated then and carried through the delay.
  always_comb begin
    aSel  = W'(bus.a >> (int'(sel_q) * W));
    bSel  = W'(bus.b >> (int'(sel_q) * W));
    res_d = (bus.op[sel_q] == OP_AND2) ? (aSel & bSel) : aSel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= IDW'(N - 1);
      sel_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      z_q      <= '0;
      zValid_q <= 1'b0;
      zId_q    <= '0;
    end else begin
      gnt_q    <= '0;
      zValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pickAny) begin
            sel_q   <= pickSel;
            gnt_q   <= pickOnehot;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          ptr_q <= sel_q;
          res_q <= res_d;
          cnt_q <= CNTW'(DIZ - 1);
          if (DIZ == 1) begin
            z_q      <= res_d;
            zId_q    <= sel_q;
            zValid_q <= 1'b1;
            state_q  <= DONE;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            z_q      <= res_q;
            zId_q    <= sel_q;
            zValid_q <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.z       = z_q;
  assign bus.z_valid = zValid_q;
  assign bus.z_id    = zId_q;

endmodule

// File: tb/tb_gate_eval_sched.sv
// Bench for gate_eval_sched: a DIZ=6 and a DIZ=1 instance checked every cycle
// against a timeline model (grant/done cycles), plus directed scenarios.
module tb_gate_eval_sched;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;
  localparam int DIZA = 6;
  localparam int DIZB = 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  gate_eval_sched_if #(.N(N), .W(W), .IDW(IDW)) busA ();
  gate_eval_sched_if #(.N(N), .W(W), .IDW(IDW)) busB ();

  gate_eval_sched #(.N(N), .W(W), .DIZ(DIZA), .IDW(IDW)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA.slave)
  );

  gate_eval_sched #(.N(N), .W(W), .DIZ(DIZB), .IDW(IDW)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit checksOn = 1'b0;

  logic [N-1:0]   reqD [2];
  logic [N-1:0]   opD  [2];
  logic [N*W-1:0] aD   [2];
  logic [N*W-1:0] bD   [2];
  logic           rstD;

  // Model: when each operation is granted and finishes, and what it returns.
  int         mGrant   [2];
  int         mDone    [2];
  int         mNextArb [2];
  int         mPtr     [2];
  int         mSel     [2];
  int         mZid     [2];
  logic [W-1:0] mRes   [2];
  logic [W-1:0] mZ     [2];

  int logSel;
  int gId[$];
  int gCyc[$];
  int zCyc[$];
  int zVal[$];
  int zId[$];
  int busyCnt;

  function automatic int dizOf(input int k);
    return (k == 0) ? DIZA : DIZB;
  endfunction

  function automatic logic [W-1:0] sliceOf(input logic [N*W-1:0] v, input int i);
    return W'(v >> (i * W));
  endfunction

  function automatic logic [N*W-1:0] setSlice(input logic [N*W-1:0] v, input int i,
                                              input logic [W-1:0] x);
    logic [N*W-1:0] mask;
    mask = (N*W)'({W{1'b1}}) << (i * W);
    return (v & ~mask) | ((N*W)'(x) << (i * W));
  endfunction

  function automatic bit bitOf(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  function automatic int qGet(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, got, want);
    end
  endtask

  task automatic sampleOutputs();
    logic [N-1:0]   g;
    logic [N-1:0]   eg;
    logic           bz;
    logic           zv;
    logic [W-1:0]   zz;
    logic [IDW-1:0] zi;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        g = busA.gnt; bz = busA.busy; zv = busA.z_valid; zz = busA.z; zi = busA.z_id;
      end else begin
        g = busB.gnt; bz = busB.busy; zv = busB.z_valid; zz = busB.z; zi = busB.z_id;
      end
      eg = '0;
      if (cyc == mGrant[k]) eg = N'(1) << mSel[k];
      checkOutput($sformatf("d%0d_gnt", k), 32'(g), 32'(eg));
      checkOutput($sformatf("d%0d_busy", k), 32'(bz), 32'(cyc >= mGrant[k] && cyc <= mDone[k]));
      checkOutput($sformatf("d%0d_zvalid", k), 32'(zv), 32'(cyc == mDone[k]));
      checkOutput($sformatf("d%0d_z", k), 32'(zz), 32'(mZ[k]));
      checkOutput($sformatf("d%0d_zid", k), 32'(zi), 32'(mZid[k]));
      if (k == logSel) begin
        for (int i = 0; i < N; i++) begin
          if (bitOf(g, i)) begin
            gId.push_back(i);
            gCyc.push_back(cyc);
          end
        end
        if (zv === 1'b1) begin
          zCyc.push_back(cyc);
          zVal.push_back(int'(zz));
          zId.push_back(int'(zi));
        end
        if (bz === 1'b1) busyCnt++;
      end
    end
  endtask

  // Inputs of cycle cyc decide the outputs of cycle cyc+1.
  task automatic modelStep();
    int win;
    int cand;
    for (int k = 0; k < 2; k++) begin
      if (rstD) begin
        mGrant[k]   = -100;
        mDone[k]    = -100;
        mNextArb[k] = cyc + 1;
        mPtr[k]     = N - 1;
        mZ[k]       = '0;
        mZid[k]     = 0;
      end else begin
        if (cyc == mGrant[k]) begin
          if (bitOf(opD[k], mSel[k]))
            mRes[k] = sliceOf(aD[k], mSel[k]) & sliceOf(bD[k], mSel[k]);
          else
            mRes[k] = sliceOf(aD[k], mSel[k]);
        end
        if (cyc + 1 == mDone[k]) begin
          mZ[k]   = mRes[k];
          mZid[k] = mSel[k];
        end
        if (cyc >= mNextArb[k] && reqD[k] != '0) begin
          win = -1;
          for (int s = 1; s <= N; s++) begin
            cand = (mPtr[k] + s) % N;
            if (win < 0 && bitOf(reqD[k], cand)) win = cand;
          end
          mSel[k]     = win;
          mPtr[k]     = win;
          mGrant[k]   = cyc + 1;
          mDone[k]    = cyc + 1 + dizOf(k);
          mNextArb[k] = mDone[k] + 1;
        end
      end
    end
  endtask

  // Clients drop their request in the cycle they see their grant.
  task automatic applyStimulus();
    for (int k = 0; k < 2; k++)
      if (cyc == mGrant[k]) reqD[k] &= ~(N'(1) << mSel[k]);
    busA.req = reqD[0]; busA.op = opD[0]; busA.a = aD[0]; busA.b = bD[0];
    busB.req = reqD[1]; busB.op = opD[1]; busB.a = aD[1]; busB.b = bD[1];
    reset    = rstD;
    modelStep();
  endtask

  task automatic nextCycle();
    @(negedge clk);
    cyc++;
    if (checksOn) sampleOutputs();
  endtask

  task automatic runIdle(input int n);
    repeat (n) begin
      nextCycle();
      applyStimulus();
    end
  endtask

  task automatic clearLogs(input int sel);
    logSel = sel;
    gId.delete(); gCyc.delete(); zCyc.delete(); zVal.delete(); zId.delete();
    busyCnt = 0;
  endtask

  task automatic randomClients(input int k);
    for (int i = 0; i < N; i++) begin
      if (cyc == mGrant[k] && mSel[k] == i) begin
        // granted: dropped by applyStimulus, operands held
      end else if (!bitOf(reqD[k], i)) begin
        if ($urandom_range(0, 3) == 0) begin
          reqD[k] |= N'(1) << i;
          opD[k]   = (opD[k] & ~(N'(1) << i)) | (N'($urandom_range(0, 1)) << i);
          aD[k]    = setSlice(aD[k], i, W'($urandom));
          bD[k]    = setSlice(bD[k], i, W'($urandom));
        end
      end else if ($urandom_range(0, 19) == 0) begin
        reqD[k] &= ~(N'(1) << i);
      end
    end
  endtask

  initial begin
    int c0;
    for (int k = 0; k < 2; k++) begin
      reqD[k] = '0; opD[k] = '0; aD[k] = '0; bD[k] = '0;
      mGrant[k] = -100; mDone[k] = -100; mNextArb[k] = 0; mPtr[k] = N - 1;
      mSel[k] = 0; mZid[k] = 0; mRes[k] = '0; mZ[k] = '0;
    end
    rstD = 1'b1;
    clearLogs(0);
    @(negedge clk);
    applyStimulus();
    checksOn = 1'b1;

    // Reset state, then a single AND2 request from client 0.
    nextCycle();
    rstD    = 1'b0;
    reqD[0] = 4'b0001;
    opD[0]  = 4'b0001;
    aD[0]   = setSlice(aD[0], 0, 8'hF0);
    bD[0]   = setSlice(bD[0], 0, 8'h3C);
    c0      = cyc;
    applyStimulus();
    runIdle(10);
    checkOutput("t1_ngnt", gId.size(), 1);
    checkOutput("t1_gnt_id", qGet(gId, 0), 0);
    checkOutput("t1_gnt_lat", qGet(gCyc, 0) - c0, 1);
    checkOutput("t1_nzv", zCyc.size(), 1);
    checkOutput("t1_zv_lat", qGet(zCyc, 0) - qGet(gCyc, 0), DIZA);
    checkOutput("t1_z", qGet(zVal, 0), 32'h30);
    checkOutput("t1_zid", qGet(zId, 0), 0);
    checkOutput("t1_busy_len", busyCnt, DIZA + 1);

    // All four clients held, BUF: strict rotation, DIZ+2 apart.
    nextCycle();
    rstD = 1'b1;
    applyStimulus();
    nextCycle();
    rstD = 1'b0;
    clearLogs(0);
    opD[0] = '0;
    for (int i = 0; i < N; i++) aD[0] = setSlice(aD[0], i, W'(8'h10 + i));
    reqD[0] = 4'b1111;
    c0      = cyc;
    applyStimulus();
    repeat (40) begin
      nextCycle();
      reqD[0] = 4'b1111;
      applyStimulus();
    end
    nextCycle();
    reqD[0] = '0;
    applyStimulus();
    runIdle(12);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t2_gnt%0d", i), qGet(gId, i), i % N);
      checkOutput($sformatf("t2_z%0d", i), qGet(zVal, i), 32'h10 + (i % N));
    end
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("t2_gap%0d", i), qGet(gCyc, i + 1) - qGet(gCyc, i), DIZA + 2);
    checkOutput("t2_first_lat", qGet(gCyc, 0) - c0, 1);

    // Pointer wrap: after client 3, client 0 wins over client 3.
    clearLogs(0);
    nextCycle();
    reqD[0] = 4'b1000;
    applyStimulus();
    runIdle(9);
    nextCycle();
    reqD[0] |= 4'b1001;
    applyStimulus();
    runIdle(20);
    checkOutput("t3_gnt0", qGet(gId, 0), 3);
    checkOutput("t3_gnt1", qGet(gId, 1), 0);
    checkOutput("t3_gnt2", qGet(gId, 2), 3);

    // Withdraw: client 2 raises and drops its request while client 1 waits.
    clearLogs(0);
    nextCycle();
    reqD[0] = 4'b0010;
    applyStimulus();
    runIdle(2);
    nextCycle();
    reqD[0] |= 4'b0100;
    applyStimulus();
    runIdle(1);
    nextCycle();
    reqD[0] &= ~4'b0100;
    applyStimulus();
    runIdle(14);
    checkOutput("t4_ngnt", gId.size(), 1);
    checkOutput("t4_gnt_id", qGet(gId, 0), 1);
    checkOutput("t4_nzv", zCyc.size(), 1);

    // Reset three cycles after grant: operation silently discarded.
    clearLogs(0);
    nextCycle();
    reqD[0] = 4'b0100;
    applyStimulus();
    runIdle(2);
    nextCycle();
    rstD = 1'b1;
    applyStimulus();
    nextCycle();
    checkOutput("t5_busy_after_rst", 32'(busA.busy), 0);
    checkOutput("t5_z_after_rst", 32'(busA.z), 0);
    rstD = 1'b0;
    applyStimulus();
    runIdle(10);
    checkOutput("t5_nzv", zCyc.size(), 0);
    checkOutput("t5_z_hold", 32'(busA.z), 0);
    nextCycle();
    reqD[0] = 4'b0101;
    applyStimulus();
    runIdle(20);
    checkOutput("t5_gnt_first", qGet(gId, 1), 0);
    checkOutput("t5_gnt_second", qGet(gId, 2), 2);

    // DIZ=1 instance: result the cycle after grant, next grant 3 cycles on.
    clearLogs(1);
    nextCycle();
    reqD[1] = 4'b1010;
    opD[1]  = '0;
    aD[1]   = setSlice(aD[1], 1, 8'hA5);
    aD[1]   = setSlice(aD[1], 3, 8'h5A);
    applyStimulus();
    runIdle(10);
    checkOutput("t6_gnt_id", qGet(gId, 0), 1);
    checkOutput("t6_zv_lat", qGet(zCyc, 0) - qGet(gCyc, 0), 1);
    checkOutput("t6_z", qGet(zVal, 0), 32'hA5);
    checkOutput("t6_zid", qGet(zId, 0), 1);
    checkOutput("t6_gap_ge3", 32'((qGet(gCyc, 1) - qGet(gCyc, 0)) >= 3), 1);
    checkOutput("t6_gnt2_id", qGet(gId, 1), 3);
    checkOutput("t6_z2", qGet(zVal, 1), 32'h5A);

    // Random clients on both instances, with occasional resets.
    clearLogs(0);
    repeat (600) begin
      nextCycle();
      randomClients(0);
      randomClients(1);
      rstD = ($urandom_range(0, 199) == 0);
      applyStimulus();
    end
    nextCycle();
    rstD    = 1'b0;
    reqD[0] = '0;
    reqD[1] = '0;
    applyStimulus();
    runIdle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
